// File: rtl/ic.sv
// rtl/ic.sv - incrementer/decrementer with toggle chain, result register and snapshot restore (optional IC_SATURATE_EN)
module ic #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N:0]   count,
    input  logic         decInc,
    input  logic         oneOrTwo,
    input  logic         enable,
    input  logic         save,
    input  logic         restore,
    output logic [N:0]   andOutput,
    output logic [N:0]   xorOutput,
    output logic [N:0]   regOutput,
    output logic [N:0]   snapOutput
);

    logic [N:0] toggleChain;
    logic [N:0] rawNext;
    logic       chainOut;

    // Toggle chain: bit k flips when every lower bit (from the step position up) propagates.
    // For a decrement, a bit propagates the borrow when it is 0, hence the XOR with decInc.
    always_comb begin
        logic [N:0] propagate;
        propagate      = count ^ {(N+1){decInc}};
        toggleChain    = '0;
        toggleChain[0] = enable & ~oneOrTwo;
        toggleChain[1] = oneOrTwo ? enable : (toggleChain[0] & propagate[0]);
        for (int k = 2; k <= N; k++) begin
            toggleChain[k] = toggleChain[k-1] & propagate[k-1];
        end
        // Carry or borrow leaving the MSB means the step wrapped.
        chainOut = toggleChain[N] & propagate[N];
    end

    assign andOutput = toggleChain;
    assign rawNext   = count ^ toggleChain;

`ifdef IC_SATURATE_EN
    // Clamp on wrap: an increment sticks at all-ones, a decrement sticks at zero.
    always_comb begin
        xorOutput = rawNext;
        if (chainOut) begin
            xorOutput = decInc ? '0 : '1;
        end
    end
`else
    // Plain modulo arithmetic; the chain carry-out is not needed.
    always_comb begin
        xorOutput = rawNext;
        if (chainOut) begin
            xorOutput = rawNext;
        end
    end
`endif

    // Result and snapshot registers; save+restore together swap the two values.
    always_ff @(posedge clk) begin
        if (rst) begin
            regOutput  <= '0;
            snapOutput <= '0;
        end else begin
            regOutput <= restore ? snapOutput : xorOutput;
            if (save) begin
                snapOutput <= regOutput;
            end
        end
    end

endmodule

// File: tb/tb_ic.sv
// tb/tb_ic.sv - self-checking bench for ic: vector table, save/restore sequences, random vs arithmetic model
module tb_ic;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic [N:0]   count;
    logic         decInc;
    logic         oneOrTwo;
    logic         enable;
    logic         save;
    logic         restore;
    logic [N:0]   andOutput;
    logic [N:0]   xorOutput;
    logic [N:0]   regOutput;
    logic [N:0]   snapOutput;

    int testsRun = 0;
    int testsFailed = 0;

    logic [N:0] mReg;
    logic [N:0] mSnap;

    ic #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .decInc    (decInc),
        .oneOrTwo  (oneOrTwo),
        .enable    (enable),
        .save      (save),
        .restore   (restore),
        .andOutput (andOutput),
        .xorOutput (xorOutput),
        .regOutput (regOutput),
        .snapOutput(snapOutput)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] count;
        logic       decInc;
        logic       oneOrTwo;
        logic       enable;
        logic [N:0] expAnd;
        logic [N:0] expXor;
    } vec_t;

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Arithmetic reference: next value is count +/- step; toggled bits are old ^ wrapped new.
    function automatic void model(input logic [N:0] c, input logic d, input logic s, input logic e,
                                  output logic [N:0] a, output logic [N:0] x);
        int step;
        int r;
        int wrapped;
        step    = e ? (s ? 2 : 1) : 0;
        r       = d ? int'(c) - step : int'(c) + step;
        wrapped = (r + 512) % 256;
        a       = c ^ wrapped[N:0];
        x       = wrapped[N:0];
`ifdef IC_SATURATE_EN
        if (r > 255) x = '1;
        if (r < 0)   x = '0;
`endif
    endfunction

    // One clock: check combinational outputs mid-cycle, then registers after the edge.
    task automatic tick();
        logic [N:0] expA, expX, nReg, nSnap;
        model(count, decInc, oneOrTwo, enable, expA, expX);
        @(negedge clk);
        check("andOutput", andOutput, expA);
        check("xorOutput", xorOutput, expX);
        if (rst) begin
            nReg  = '0;
            nSnap = '0;
        end else begin
            nReg  = restore ? mSnap : expX;
            nSnap = save ? mReg : mSnap;
        end
        @(posedge clk);
        #1;
        mReg  = nReg;
        mSnap = nSnap;
        check("regOutput", regOutput, mReg);
        check("snapOutput", snapOutput, mSnap);
    endtask

    task automatic setIn(input logic [N:0] c, input logic d, input logic s, input logic e,
                         input logic sv, input logic rs, input logic r);
        count = c; decInc = d; oneOrTwo = s; enable = e; save = sv; restore = rs; rst = r;
    endtask

    vec_t vecs[8];

    initial begin
        mReg  = '0;
        mSnap = '0;
        setIn(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("reset regOutput", regOutput, 8'd0);
        check("reset snapOutput", snapOutput, 8'd0);
        // Reset held with save/restore and an active step must keep both registers at 0.
        setIn(8'd77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) tick();
        check("reset hold regOutput", regOutput, 8'd0);

        vecs[0] = '{8'd5,   1'b0, 1'b0, 1'b1, 8'b0000_0011, 8'd6};
        vecs[1] = '{8'd5,   1'b1, 1'b1, 1'b1, 8'b0000_0110, 8'd3};
        vecs[2] = '{8'd9,   1'b0, 1'b0, 1'b0, 8'd0, 8'd9};
        vecs[3] = '{8'd9,   1'b0, 1'b1, 1'b0, 8'd0, 8'd9};
        vecs[4] = '{8'd9,   1'b1, 1'b0, 1'b0, 8'd0, 8'd9};
        vecs[5] = '{8'd9,   1'b1, 1'b1, 1'b0, 8'd0, 8'd9};
`ifdef IC_SATURATE_EN
        vecs[6] = '{8'd255, 1'b0, 1'b1, 1'b1, 8'hFE, 8'd255};
        vecs[7] = '{8'd0,   1'b1, 1'b0, 1'b1, 8'hFF, 8'd0};
`else
        vecs[6] = '{8'd255, 1'b0, 1'b1, 1'b1, 8'hFE, 8'd1};
        vecs[7] = '{8'd0,   1'b1, 1'b0, 1'b1, 8'hFF, 8'd255};
`endif
        for (int i = 0; i < 8; i++) begin
            setIn(vecs[i].count, vecs[i].decInc, vecs[i].oneOrTwo, vecs[i].enable, 1'b0, 1'b0, 1'b0);
            #2;
            check($sformatf("vec%0d andOutput", i), andOutput, vecs[i].expAnd);
            check($sformatf("vec%0d xorOutput", i), xorOutput, vecs[i].expXor);
            tick();
        end

        // Save/restore: capture 6, move on to 10, restore 6.
        setIn(8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("seq reg=6", regOutput, 8'd6);
        setIn(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("seq snap=6", snapOutput, 8'd6);
        setIn(8'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("seq reg=10", regOutput, 8'd10);
        setIn(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("seq restore reg=6", regOutput, 8'd6);

        // Swap: reg=20, snap=6 -> after save+restore reg=6, snap=20.
        setIn(8'd19, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        setIn(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("swap reg", regOutput, 8'd6);
        check("swap snap", snapOutput, 8'd20);

        // Reset in the middle of a save: both clear.
        setIn(8'd50, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("mid-seq reset snap", snapOutput, 8'd0);

        for (int i = 0; i < 400; i++) begin
            setIn($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
